// File: rtl/tcdm_strided_reader.sv
// rtl/tcdm_strided_reader.sv - strided TCDM word reader with credit-limited response FIFO
module tcdm_strided_reader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [ADDR_WIDTH-1:0]   stride_i,
    input  logic [CNT_WIDTH-1:0]    length_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    tcdm_req_o,
    input  logic                    tcdm_gnt_i,
    output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
    output logic                    tcdm_wen_o,
    output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
    output logic [DATA_WIDTH-1:0]   tcdm_data_o,
    input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
    input  logic                    tcdm_r_valid_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATA_WIDTH-1:0]   out_data_o
);

    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   add_q, add_d;
    logic [ADDR_WIDTH-1:0]   stride_q, stride_d;
    logic [CNT_WIDTH-1:0]    length_q, length_d;
    logic [CNT_WIDTH-1:0]    issued_q, issued_d;
    logic [CNT_WIDTH-1:0]    credits_q, credits_d;
    logic [CNT_WIDTH-1:0]    discard_q, discard_d;
    logic                    req_q, req_d;
    logic                    done_q, done_d;
    logic [PTR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];

    logic                    grant, push, pop;
    logic [CNT_WIDTH-1:0]    issued_inc, credits_nxt, outstanding;

    assign grant       = req_q & tcdm_gnt_i;
    assign pop         = (count_q != '0) & out_ready_i;
    // Responses owed to a cleared job are swallowed instead of entering the FIFO.
    assign push        = tcdm_r_valid_i & (discard_q == '0);
    assign issued_inc  = issued_q + CNT_WIDTH'(grant);
    assign credits_nxt = credits_q + CNT_WIDTH'(grant) - CNT_WIDTH'(pop);
    assign outstanding = credits_q - CNT_WIDTH'(count_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            add_q     <= '0;
            stride_q  <= '0;
            length_q  <= '0;
            issued_q  <= '0;
            credits_q <= '0;
            discard_q <= '0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            add_q     <= add_d;
            stride_q  <= stride_d;
            length_q  <= length_d;
            issued_q  <= issued_d;
            credits_q <= credits_d;
            discard_q <= discard_d;
            req_q     <= req_d;
            done_q    <= done_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= tcdm_r_data_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        add_d     = add_q;
        stride_d  = stride_q;
        length_d  = length_q;
        issued_d  = issued_q;
        credits_d = credits_q;
        discard_d = discard_q;
        req_d     = req_q;
        done_d    = 1'b0;
        wr_ptr_d  = wr_ptr_q + PTR_WIDTH'(push);
        rd_ptr_d  = rd_ptr_q + PTR_WIDTH'(pop);
        count_d   = count_q + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pop);

        if (discard_q != '0 && tcdm_r_valid_i) begin
            discard_d = discard_q - 1'b1;
        end

        if (clear_i) begin
            state_d   = IDLE;
            req_d     = 1'b0;
            issued_d  = '0;
            credits_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            // Everything still on the bus after this cycle must be discarded.
            discard_d = discard_q + outstanding + CNT_WIDTH'(grant)
                      - CNT_WIDTH'(tcdm_r_valid_i);
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && discard_q == '0) begin
                        if (length_i != '0) begin
                            state_d   = RUN;
                            add_d     = base_addr_i;
                            stride_d  = stride_i;
                            length_d  = length_i;
                            issued_d  = '0;
                            credits_d = '0;
                            req_d     = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    issued_d  = issued_inc;
                    credits_d = credits_nxt;
                    if (grant) begin
                        add_d = add_q + stride_q;
                    end
                    if (issued_inc == length_q) begin
                        state_d = DRAIN;
                        req_d   = 1'b0;
                    end else begin
                        req_d = (credits_nxt < DEPTH_CNT);
                    end
                end
                DRAIN: begin
                    credits_d = credits_nxt;
                    if (credits_nxt == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign tcdm_req_o  = req_q;
    assign tcdm_add_o  = add_q;
    assign tcdm_wen_o  = 1'b1;
    assign tcdm_be_o   = '1;
    assign tcdm_data_o = '0;
    assign out_valid_o = (count_q != '0);
    assign out_data_o  = fifo_mem[rd_ptr_q];

endmodule

// File: tb/tb_tcdm_strided_reader.sv
// tb/tb_tcdm_strided_reader.sv - self-checking bench for tcdm_strided_reader
module tb_tcdm_strided_reader;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] stride = '0;
    logic [15:0] length = '0;
    logic        busy, done, req, gnt, wen;
    logic [31:0] add, wdata, out_data;
    logic [3:0]  be;
    logic [31:0] r_data = '0;
    logic        r_valid = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        gnt_en = 1'b1;
    logic        rand_mode = 1'b0;

    int checks = 0;
    int errors = 0;
    int cycle_count = 0;
    int t0 = 0;
    int first_req_rel, done_rel, busy_fall_rel, done_count;
    logic [31:0] grant_addrs[$];
    logic [31:0] pop_data[$];
    int          pop_rel[$];
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_clear = 1'b0;
    logic        prev_req = 1'b0, prev_gnt = 1'b0;
    logic [31:0] prev_data = '0, prev_add = '0;

    tcdm_strided_reader #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
        .base_addr_i(base_addr), .stride_i(stride), .length_i(length),
        .busy_o(busy), .done_o(done),
        .tcdm_req_o(req), .tcdm_gnt_i(gnt), .tcdm_add_o(add),
        .tcdm_wen_o(wen), .tcdm_be_o(be), .tcdm_data_o(wdata),
        .tcdm_r_data_i(r_data), .tcdm_r_valid_i(r_valid),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    // Dummy TCDM slave: grant is combinational from req, data returns one cycle later.
    assign gnt = req & gnt_en;
    always @(posedge clk) begin
        cycle_count <= cycle_count + 1;
        if (rst) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= req & gnt;
            r_data  <= mem_word(add);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_mode) begin
            gnt_en    = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            automatic int rel = cycle_count - t0;
            if (req && first_req_rel < 0) first_req_rel = rel;
            if (req && gnt) grant_addrs.push_back(add);
            if (out_valid && out_ready) begin
                pop_data.push_back(out_data);
                pop_rel.push_back(rel);
            end
            if (done) begin
                done_count++;
                done_rel = rel;
            end
            if (!busy && busy_fall_rel < 0 && rel > 0) busy_fall_rel = rel;
            if (prev_valid && !prev_ready && !prev_clear) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", out_data, prev_data);
            end
            if (prev_req && !prev_gnt && !prev_clear) begin
                chk("req_stable", 32'(req), 32'd1);
                chk("add_stable", add, prev_add);
            end
            chk("credit_bound", 32'(grant_addrs.size() <= pop_data.size() + DEPTH), 32'd1);
            prev_valid = out_valid; prev_ready = out_ready; prev_data = out_data;
            prev_req = req; prev_gnt = gnt; prev_add = add; prev_clear = clear;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_job(input logic [31:0] b, input logic [31:0] s, input logic [15:0] l);
        grant_addrs.delete(); pop_data.delete(); pop_rel.delete();
        first_req_rel = -1; done_rel = -1; busy_fall_rel = -1; done_count = 0;
        t0 = cycle_count;
        base_addr = b; stride = s; length = l; start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done_count == 0 && n < budget) begin
            step(1);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_count > 0), 32'd1);
        step(3);
    endtask

    task automatic check_job(input string tag, input logic [31:0] b, input logic [31:0] s,
                             input int l);
        chk({tag, "_grants"}, 32'(grant_addrs.size()), 32'(l));
        chk({tag, "_pops"}, 32'(pop_data.size()), 32'(l));
        chk({tag, "_done_once"}, 32'(done_count), 32'd1);
        for (int i = 0; i < l; i++) begin
            automatic logic [31:0] a = b + 32'(i) * s;
            if (i < grant_addrs.size()) chk({tag, "_addr"}, grant_addrs[i], a);
            if (i < pop_data.size()) chk({tag, "_data"}, pop_data[i], mem_word(a));
        end
    endtask

    initial begin
        first_req_rel = -1; done_rel = -1; busy_fall_rel = -1; done_count = 0;
        step(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_add", add, 32'd0);
        chk("wen_const", 32'(wen), 32'd1);
        chk("be_const", 32'(be), 32'hF);
        chk("wdata_const", wdata, 32'd0);
        rst = 1'b0;
        step(2);

        // Basic reference timing
        start_job(32'h100, 32'd4, 16'd8);
        wait_done(200, "basic");
        check_job("basic", 32'h100, 32'd4, 8);
        chk("basic_first_req", 32'(first_req_rel), 32'd1);
        chk("basic_done_cycle", 32'(done_rel), 32'd11);
        chk("basic_busy_fall", 32'(busy_fall_rel), 32'd11);
        for (int i = 0; i < pop_rel.size(); i++) chk("basic_word_cycle", 32'(pop_rel[i]), 32'(i + 3));

        // Backpressure
        out_ready = 1'b0;
        start_job(32'h100, 32'd4, 16'd8);
        step(19);
        chk("bp_grants", 32'(grant_addrs.size()), 32'd4);
        chk("bp_req_low", 32'(req), 32'd0);
        chk("bp_no_done", 32'(done_count), 32'd0);
        step(1);
        out_ready = 1'b1;
        wait_done(200, "bp");
        check_job("bp", 32'h100, 32'd4, 8);

        // Random stalls on grant and ready
        for (int j = 0; j < 2; j++) begin
            automatic logic [31:0] b = $urandom & 32'hFFFF_FFFC;
            automatic int sw = int'($urandom_range(0, 16)) - 8;
            automatic logic [31:0] s = 32'(sw * 4);
            rand_mode = 1'b1;
            start_job(b, s, 16'd64);
            wait_done(3000, "rand");
            rand_mode = 1'b0;
            gnt_en = 1'b1; out_ready = 1'b1;
            step(2);
            check_job("rand", b, s, 64);
        end

        // Negative stride with address wrap
        start_job(32'h8, 32'hFFFF_FFFC, 16'd4);
        wait_done(100, "neg");
        check_job("neg", 32'h8, 32'hFFFF_FFFC, 4);
        chk("neg_last_addr", grant_addrs.size() == 4 ? grant_addrs[3] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);

        // Zero length
        start_job(32'h40, 32'd4, 16'd0);
        step(4);
        chk("zero_done_cycle", 32'(done_rel), 32'd1);
        chk("zero_done_once", 32'(done_count), 32'd1);
        chk("zero_no_req", 32'(first_req_rel), 32'hFFFF_FFFF);

        // start while busy is ignored
        start_job(32'h300, 32'd8, 16'd6);
        step(2);
        base_addr = 32'h999; stride = 32'd12; length = 16'd2; start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(100, "busy_start");
        check_job("busy_start", 32'h300, 32'd8, 6);
        chk("busy_start_done_cycle", 32'(done_rel), 32'd9);

        // Clear one cycle after the third grant
        start_job(32'h100, 32'd4, 16'd8);
        step(3);
        chk("clr_grants_before", 32'(grant_addrs.size()), 32'd3);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_req", 32'(req), 32'd0);
        step(2);
        chk("clr_no_done", 32'(done_count), 32'd0);
        chk("clr_fifo_empty", 32'(out_valid), 32'd0);
        start_job(32'h200, 32'd4, 16'd2);
        wait_done(100, "clr_new");
        check_job("clr_new", 32'h200, 32'd4, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

endmodule
